// File: rtl/mash_noise_cancel.sv
// rtl/mash_noise_cancel.sv - MASH DDSM noise-cancellation stage: Y = C1 + (1-z^-1)C2 + (1-z^-1)^2 C3
// Optional MASH_NCL_PIPE_EN adds a register between the partial sums and the final adder (latency 2).
module mash_noise_cancel #(
  parameter int P_ORDER     = 3,
  parameter int P_OUT_WIDTH = 4,
  parameter int P_OFFSET    = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic                          i_clr,
  input  logic                          i_c1,
  input  logic                          i_c2,
  input  logic                          i_c3,
  output logic signed [P_OUT_WIDTH-1:0] o_y,
  output logic        [P_OUT_WIDTH-1:0] o_y_off,
  output logic                          o_valid
);

  localparam int W = P_OUT_WIDTH;
  localparam logic [W-1:0] OFF = W'(P_OFFSET);

  function automatic logic signed [W-1:0] ext(input logic b);
    return {{(W-1){1'b0}}, b};
  endfunction

  // Stages beyond the configured order contribute nothing and keep zero history.
  logic c1_g, c2_g, c3_g;
  assign c1_g = i_c1;
  assign c2_g = (P_ORDER >= 2) ? i_c2 : 1'b0;
  assign c3_g = (P_ORDER >= 3) ? i_c3 : 1'b0;

  logic c2_d1, c3_d1, c3_d2;
  logic signed [W-1:0] t1, t2, t3;

  assign t1 = ext(c1_g);
  assign t2 = ext(c2_g) - ext(c2_d1);
  assign t3 = ext(c3_g) - ext(c3_d1) - ext(c3_d1) + ext(c3_d2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c2_d1 <= 1'b0;
      c3_d1 <= 1'b0;
      c3_d2 <= 1'b0;
    end else if (i_clr) begin
      c2_d1 <= 1'b0;
      c3_d1 <= 1'b0;
      c3_d2 <= 1'b0;
    end else if (i_en) begin
      c2_d1 <= c2_g;
      c3_d2 <= c3_d1;
      c3_d1 <= c3_g;
    end
  end

  logic signed [W-1:0] sum_c;
  logic                fin_v;

`ifdef MASH_NCL_PIPE_EN
  logic signed [W-1:0] p1, p2, p3;
  logic                p_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p1      <= '0;
      p2      <= '0;
      p3      <= '0;
      p_valid <= 1'b0;
    end else if (i_clr) begin
      p1      <= '0;
      p2      <= '0;
      p3      <= '0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= i_en;
      if (i_en) begin
        p1 <= t1;
        p2 <= t2;
        p3 <= t3;
      end
    end
  end

  assign sum_c = p1 + p2 + p3;
  assign fin_v = p_valid;
`else
  assign sum_c = t1 + t2 + t3;
  assign fin_v = i_en;
`endif

  // o_y_off derives from the same sum so both outputs always describe one sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_y     <= '0;
      o_y_off <= '0;
      o_valid <= 1'b0;
    end else if (i_clr) begin
      o_y     <= '0;
      o_y_off <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= fin_v;
      if (fin_v) begin
        o_y     <= sum_c;
        o_y_off <= sum_c + OFF;
      end
    end
  end

endmodule
